gpr_mp: RTL and testbench



---
 rtl/gpr_mp_if.sv | 31 +++
 rtl/gpr_mp.sv | 121 ++++++++++++
 tb/tb_gpr_mp.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : gpr_mp_if
// Description : Write/read/status bundle for the gpr_mp register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpr_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       clr;
    logic                       we;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic                       busy;
    logic                       wr_drop;

    modport master (
        output clr, we, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, wr_drop
    );

    modport slave (
        input  clr, we, wr_addr, wr_data, rd_addr,
        output rd_data, busy, wr_drop
    );
endinterface
`default_nettype wire

// File: rtl/gpr_mp.sv
`default_nettype none
// ============================================================================
// Module      : gpr_mp
// Description : Multi-read-port register file with optional zero register,
//               write bypass and a sequential clear walk after reset/clr.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic      clk,
    input  logic      reset,
    gpr_mp_if.slave   bus
);
    localparam int                c_depth     = 2 ** ADDR_W;
    localparam logic [0:0]        c_idle      = 1'b0;
    localparam logic [0:0]        c_clear     = 1'b1;
    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_wr_drop;
    logic              w_wr_drop_nxt;
    logic              w_busy;
    logic              w_zero_hit;
    logic              w_wr_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] r_mem [c_depth];

    assign w_busy     = (r_state == c_clear);
    assign w_zero_hit = (ZERO_REG != 0) && (bus.wr_addr == '0);
    // A user write that actually lands in the array this cycle.
    assign w_wr_ok    = bus.we && !w_busy && !w_zero_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_clear;
            r_cnt     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_drop <= w_wr_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wr_drop_nxt = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = bus.wr_addr;
        w_mem_data    = bus.wr_data;
        case (r_state)
            c_idle: begin
                w_mem_we      = w_wr_ok;
                w_wr_drop_nxt = bus.we && w_zero_hit;
                if (bus.clr) begin
                    w_state_nxt = c_clear;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_wr_drop_nxt = bus.we;
                if (bus.clr) begin
                    w_cnt_nxt = '0;
                end else begin
                    // The walk owns the single write port while clearing.
                    w_mem_we   = 1'b1;
                    w_mem_addr = r_cnt;
                    w_mem_data = '0;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == c_last_addr) begin
                        w_state_nxt = c_idle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !reset) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;

            assign w_addr = bus.rd_addr[k*ADDR_W +: ADDR_W];

            always_comb begin
                if (w_busy) begin
                    w_data = '0;
                end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_data = '0;
                end else if ((BYPASS != 0) && w_wr_ok && (w_addr == bus.wr_addr)) begin
                    w_data = bus.wr_data;
                end else begin
                    w_data = r_mem[w_addr];
                end
            end

            assign bus.rd_data[k*DATA_W +: DATA_W] = w_data;
        end
    endgenerate

    assign bus.busy    = w_busy;
    assign bus.wr_drop = r_wr_drop;
endmodule
`default_nettype wire

// File: tb/tb_gpr_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_mp
// Description : Bench for gpr_mp: instance A (2 ports, zero reg, bypass) and
//               instance B (4 ports, no zero reg, no bypass) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_mp;
    localparam int c_depth = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gpr_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ia ();
    gpr_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) ib ();

    assign ia.clr     = clr;
    assign ia.we      = we;
    assign ia.wr_addr = wr_addr;
    assign ia.wr_data = wr_data;
    assign ia.rd_addr = {ra[1], ra[0]};
    assign ib.clr     = clr;
    assign ib.we      = we;
    assign ib.wr_addr = wr_addr;
    assign ib.wr_data = wr_data;
    assign ib.rd_addr = {ra[3], ra[2], ra[1], ra[0]};

    gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia)
    );
    gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ib)
    );

    // Reference model: a walk is a block of c_depth busy edges after which
    // the whole array is zero; nothing can land meanwhile, so zero up front.
    logic [31:0] mem_a [c_depth];
    logic [31:0] mem_b [c_depth];
    int          left;
    logic        drop_a, drop_b;

    function automatic void zero_all();
        for (int i = 0; i < c_depth; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    endfunction

    function automatic void model_edge();
        if (reset) begin
            left = c_depth; drop_a = 0; drop_b = 0;
            zero_all();
        end else if (left > 0) begin
            drop_a = we; drop_b = we;
            left = clr ? c_depth : left - 1;
        end else begin
            drop_a = 0; drop_b = 0;
            if (we) begin
                if (wr_addr == 0) drop_a = 1;
                else mem_a[wr_addr] = wr_data;
                mem_b[wr_addr] = wr_data;
            end
            if (clr) begin
                left = c_depth;
                zero_all();
            end
        end
    endfunction

    function automatic logic [31:0] exp_rd(bit is_a, logic [4:0] a);
        if (left > 0) return '0;
        if (is_a) begin
            if (a == 0) return '0;
            if (we && a == wr_addr && wr_addr != 0) return wr_data;
            return mem_a[a];
        end
        return mem_b[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Compare every output with the model, then advance one clock.
    task automatic tick();
        #1;
        chk("busy_a", 32'(ia.busy), 32'(left > 0));
        chk("busy_b", 32'(ib.busy), 32'(left > 0));
        chk("drop_a", 32'(ia.wr_drop), 32'(drop_a));
        chk("drop_b", 32'(ib.wr_drop), 32'(drop_b));
        for (int k = 0; k < 2; k++) chk($sformatf("rd_a%0d", k), ia.rd_data[k*32 +: 32], exp_rd(1'b1, ra[k]));
        for (int k = 0; k < 4; k++) chk($sformatf("rd_b%0d", k), ib.rd_data[k*32 +: 32], exp_rd(1'b0, ra[k]));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (ia.busy === 1'b1 && n < 100) begin
            n++;
            tick();
            we = 1'b0;
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0, r1;
        logic [31:0] a0, a1, b0, b1;
        logic        da, db;
    } vec_t;

    vec_t vecs [6];
    int   n;

    initial begin : main
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd0, 32'h1234, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234, 32'h1234, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h1234, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};

        reset = 1'b1; clr = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
        for (int k = 0; k < 4; k++) ra[k] = 5'(k);
        left = 0; drop_a = 0; drop_b = 0;
        zero_all();

        // Reset held for 3 edges; state is unknown before the first one.
        @(posedge clk); model_edge(); @(negedge clk);
        tick(); tick();
        reset = 1'b0;
        count_busy(n);
        chk("reset_walk_len", n, 32);
        for (int i = 0; i < c_depth; i++) begin
            ra[0] = 5'(i); ra[1] = 5'(31 - i); ra[2] = 5'(i); ra[3] = 5'(31 - i);
            #1;
            chk("post_walk_zero_b", ib.rd_data[31:0], 32'h0);
            tick();
        end

        ra[2] = '0; ra[3] = '0;
        foreach (vecs[i]) begin
            we = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            ra[0] = vecs[i].r0; ra[1] = vecs[i].r1;
            #1;
            chk($sformatf("vec%0d_a0", i), ia.rd_data[31:0],  vecs[i].a0);
            chk($sformatf("vec%0d_a1", i), ia.rd_data[63:32], vecs[i].a1);
            chk($sformatf("vec%0d_b0", i), ib.rd_data[31:0],  vecs[i].b0);
            chk($sformatf("vec%0d_b1", i), ib.rd_data[63:32], vecs[i].b1);
            chk($sformatf("vec%0d_da", i), 32'(ia.wr_drop), 32'(vecs[i].da));
            chk($sformatf("vec%0d_db", i), 32'(ib.wr_drop), 32'(vecs[i].db));
            tick();
        end

        // Four read ports on instance B.
        we = 1'b1;
        wr_addr = 5'd1;  wr_data = 32'h11111111; tick();
        wr_addr = 5'd2;  wr_data = 32'h22222222; tick();
        wr_addr = 5'd31; wr_data = 32'h33333333; tick();
        we = 1'b0;
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd1; ra[3] = 5'd31;
        #1;
        chk("four_p0", ib.rd_data[31:0],   32'h11111111);
        chk("four_p1", ib.rd_data[63:32],  32'h22222222);
        chk("four_p2", ib.rd_data[95:64],  32'h11111111);
        chk("four_p3", ib.rd_data[127:96], 32'h33333333);
        chk("four_p0_eq_p2", ib.rd_data[31:0], ib.rd_data[95:64]);
        tick();

        // Write during clear: dropped, and r3/r7 end up zero.
        clr = 1'b1; ra[0] = 5'd7; ra[1] = 5'd3;
        #1;
        chk("pre_clr_r7", ia.rd_data[31:0], 32'hA5A5A5A5);
        tick();
        clr = 1'b0; we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF;
        #1;
        chk("clr_busy", 32'(ia.busy), 32'd1);
        tick();
        we = 1'b0;
        chk("clr_wr_drop", 32'(ia.wr_drop), 32'd1);
        count_busy(n);
        chk("clr_walk_len", n + 1, 32);
        #1;
        chk("clr_r7_a", ia.rd_data[31:0],  32'h0);
        chk("clr_r3_a", ia.rd_data[63:32], 32'h0);
        chk("clr_r7_b", ib.rd_data[31:0],  32'h0);
        tick();

        // Reset at walk cycle 10 restarts the full walk.
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (10) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        count_busy(n);
        chk("midwalk_reset_len", n, 32);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            reset   = ($urandom_range(0, 199) == 0);
            clr     = ($urandom_range(0, 99) == 0);
            we      = $urandom_range(0, 1);
            wr_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wr_data = $urandom;
            for (int k = 0; k < 4; k++)
                ra[k] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
